// File: rtl/bus_per_pkg.sv
// Shared types, state codes and the default 8-slave address map for the
// parametrised peripheral bus switch.
package bus_per_pkg;

  localparam int DEF_N_SLAVES = 8;
  localparam int DEF_ADR_W    = 32;

  typedef logic [1:0] bus_state_t;

  localparam bus_state_t ST_IDLE = 2'd0;
  localparam bus_state_t ST_BUSY = 2'd1;
  localparam bus_state_t ST_ERR  = 2'd2;

  typedef enum logic {
    ERR_SRC_ADR = 1'b0,
    ERR_SRC_TO  = 1'b1
  } err_src_e;

  // Peripheral map: 4 KiB windows at 0x1000_0000 + i*0x1000, slave 0 in the low word
  localparam logic [DEF_N_SLAVES*DEF_ADR_W-1:0] DEF_SLV_BASE = {
    32'h1000_7000, 32'h1000_6000, 32'h1000_5000, 32'h1000_4000,
    32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000
  };

  localparam logic [DEF_N_SLAVES*DEF_ADR_W-1:0] DEF_SLV_MASK = {
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decoder_n.sv
// Combinational base/mask window decoder; lowest-index hit has priority.
module bus_addr_decoder_n
  import bus_per_pkg::*;
#(
  parameter int                          N_SLAVES = DEF_N_SLAVES,
  parameter int                          ADR_W    = DEF_ADR_W,
  parameter int                          IDX_W    = idx_width(N_SLAVES),
  parameter logic [N_SLAVES*ADR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLAVES*ADR_W-1:0]   SLV_MASK = DEF_SLV_MASK
) (
  input  logic [ADR_W-1:0]    adr,
  input  logic                stb,
  output logic [N_SLAVES-1:0] hit,
  output logic [N_SLAVES-1:0] onehot,
  output logic [IDX_W-1:0]    idx,
  output logic                miss
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      hit[i] = stb && ((adr & SLV_MASK[i*ADR_W +: ADR_W]) == SLV_BASE[i*ADR_W +: ADR_W]);
    end
  end

  assign onehot = hit & (~hit + N_SLAVES'(1));
  assign miss   = stb && !(|hit);

  always_comb begin
    idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bus_switch_per_n.sv
// One-master, N-slave peripheral bus switch with unmapped-address and
// ack-watchdog error termination plus faulting-address capture.
module bus_switch_per_n
  import bus_per_pkg::*;
#(
  parameter int                          N_SLAVES = DEF_N_SLAVES,
  parameter int                          ADR_W    = DEF_ADR_W,
  parameter int                          DAT_W    = 32,
  parameter int                          SEL_W    = DAT_W / 8,
  parameter logic [N_SLAVES*ADR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLAVES*ADR_W-1:0]   SLV_MASK = DEF_SLV_MASK,
  parameter int                          TIMEOUT  = 255,
  parameter int                          TO_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      master_stb_i,
  input  logic                      master_we_i,
  input  logic [ADR_W-1:0]          master_adr_i,
  input  logic [DAT_W-1:0]          master_dat_i,
  input  logic [SEL_W-1:0]          master_sel_i,
  output logic [DAT_W-1:0]          master_dat_o,
  output logic                      master_ack_o,
  output logic                      master_err_o,
  output logic                      adr_err_o,
  output logic                      to_err_o,
  output logic [ADR_W-1:0]          err_adr_o,
  input  logic [N_SLAVES*DAT_W-1:0] slave_dat_i,
  input  logic [N_SLAVES-1:0]       slave_ack_i,
  output logic [N_SLAVES-1:0]       slave_stb_o,
  output logic [N_SLAVES-1:0]       slave_cyc_o,
  output logic                      slave_we_o,
  output logic [ADR_W-1:0]          slave_adr_o,
  output logic [DAT_W-1:0]          slave_dat_o,
  output logic [SEL_W-1:0]          slave_sel_o
);

  // state   | meaning
  // IDLE    | no transfer; decode on master_stb_i
  // BUSY    | selected slave strobed, waiting for its ack, watchdog running
  // ERR     | one-cycle error termination (unmapped address or timeout)

  localparam int IDX_W = idx_width(N_SLAVES);

  bus_state_t           state;
  err_src_e             err_src;
  logic [IDX_W-1:0]     sel_idx;
  logic [N_SLAVES-1:0]  sel_oh;
  logic [ADR_W-1:0]     adr_lat;
  logic [TO_W-1:0]      wdog;

  logic [N_SLAVES-1:0]  dec_hit;
  logic [N_SLAVES-1:0]  dec_oh;
  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_miss;
  logic                 dec_any;
  logic                 sel_ack;
  logic                 busy;
  logic                 in_err;
  logic [DAT_W-1:0]     dat_sel;

  bus_addr_decoder_n #(
    .N_SLAVES (N_SLAVES),
    .ADR_W    (ADR_W),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .adr    (master_adr_i),
    .stb    (master_stb_i),
    .hit    (dec_hit),
    .onehot (dec_oh),
    .idx    (dec_idx),
    .miss   (dec_miss)
  );

  assign dec_any = |dec_hit;
  assign busy    = (state == ST_BUSY);
  assign in_err  = (state == ST_ERR);
  assign sel_ack = |(slave_ack_i & sel_oh);

  always_comb begin
    dat_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_idx == IDX_W'(i)) dat_sel = slave_dat_i[i*DAT_W +: DAT_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= ST_IDLE;
      err_src   <= ERR_SRC_ADR;
      sel_idx   <= '0;
      sel_oh    <= '0;
      adr_lat   <= '0;
      wdog      <= '0;
      err_adr_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dec_miss) begin
            err_adr_o <= master_adr_i;
            err_src   <= ERR_SRC_ADR;
            state     <= ST_ERR;
          end else if (dec_any) begin
            sel_idx <= dec_idx;
            sel_oh  <= dec_oh;
            adr_lat <= master_adr_i;
            wdog    <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // an ack in the terminal watchdog cycle still completes normally
          if (!master_stb_i || sel_ack) begin
            state <= ST_IDLE;
          end else if (wdog == TO_W'(TIMEOUT - 1)) begin
            err_adr_o <= adr_lat;
            err_src   <= ERR_SRC_TO;
            state     <= ST_ERR;
          end else if (wdog != TO_W'(TIMEOUT)) begin
            wdog <= wdog + TO_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign slave_stb_o  = (busy && master_stb_i) ? sel_oh : '0;
  assign slave_cyc_o  = slave_stb_o;
  assign master_ack_o = busy && master_stb_i && sel_ack;
  assign master_dat_o = busy ? dat_sel : '0;
  assign master_err_o = in_err;
  assign adr_err_o    = in_err && (err_src == ERR_SRC_ADR);
  assign to_err_o     = in_err && (err_src == ERR_SRC_TO);

  assign slave_we_o  = master_we_i;
  assign slave_adr_o = master_adr_i;
  assign slave_dat_o = master_dat_i;
  assign slave_sel_o = master_sel_i;

endmodule

// File: tb/tb_bus_switch_per_n.sv
// Directed bench: dut_a (TIMEOUT=8, overlapping map) and dut_b (TIMEOUT=4, default map).
module tb_bus_switch_per_n;

  localparam logic [255:0] BASE_A = {
    32'h1000_7000, 32'h1000_6000, 32'h1000_5000, 32'h1000_4000,
    32'h1000_0000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000
  };
  localparam logic [255:0] MASK_A = {
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
    32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000
  };

  logic clk = 1'b0;
  logic rst;
  logic stb, we;
  logic [31:0]  adr, wdat;
  logic [3:0]   sel;
  logic [255:0] sdat;
  logic [7:0]   sack;

  logic [31:0] a_dat, a_err_adr, a_adr, a_wdat;
  logic        a_ack, a_err, a_adr_err, a_to_err, a_we;
  logic [7:0]  a_stb, a_cyc;
  logic [3:0]  a_sel;
  logic [31:0] b_dat, b_err_adr, b_adr, b_wdat;
  logic        b_ack, b_err, b_adr_err, b_to_err, b_we;
  logic [7:0]  b_stb, b_cyc;
  logic [3:0]  b_sel;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bus_switch_per_n #(.SLV_BASE(BASE_A), .SLV_MASK(MASK_A), .TIMEOUT(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .master_stb_i(stb), .master_we_i(we),
    .master_adr_i(adr), .master_dat_i(wdat), .master_sel_i(sel),
    .master_dat_o(a_dat), .master_ack_o(a_ack), .master_err_o(a_err),
    .adr_err_o(a_adr_err), .to_err_o(a_to_err), .err_adr_o(a_err_adr),
    .slave_dat_i(sdat), .slave_ack_i(sack), .slave_stb_o(a_stb), .slave_cyc_o(a_cyc),
    .slave_we_o(a_we), .slave_adr_o(a_adr), .slave_dat_o(a_wdat), .slave_sel_o(a_sel)
  );

  bus_switch_per_n #(.TIMEOUT(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .master_stb_i(stb), .master_we_i(we),
    .master_adr_i(adr), .master_dat_i(wdat), .master_sel_i(sel),
    .master_dat_o(b_dat), .master_ack_o(b_ack), .master_err_o(b_err),
    .adr_err_o(b_adr_err), .to_err_o(b_to_err), .err_adr_o(b_err_adr),
    .slave_dat_i(sdat), .slave_ack_i(sack), .slave_stb_o(b_stb), .slave_cyc_o(b_cyc),
    .slave_we_o(b_we), .slave_adr_o(b_adr), .slave_dat_o(b_wdat), .slave_sel_o(b_sel)
  );

  task automatic test_reset();
    rst = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
    sdat = '0; sack = '0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({a_stb, a_cyc, b_stb, b_cyc} !== 32'h0) begin
      tests_failed++; $display("FAIL reset_stb: got %h want 0", {a_stb, a_cyc, b_stb, b_cyc});
    end
    tests_run++;
    if ({a_ack, a_err, a_adr_err, a_to_err, b_ack, b_err, b_adr_err, b_to_err} !== 8'h0) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 0",
        {a_ack, a_err, a_adr_err, a_to_err, b_ack, b_err, b_adr_err, b_to_err});
    end
    tests_run++;
    if (a_err_adr !== 32'h0 || a_dat !== 32'h0) begin
      tests_failed++; $display("FAIL reset_adr_dat: got %h/%h want 0/0", a_err_adr, a_dat);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_read();
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = 32'h1000_2010; sel = 4'hF; wdat = 32'hCAFE_0001;
    sdat = {8{32'h5555_AAAA}};
    #1;
    tests_run++;
    if (a_stb !== 8'h00 || a_dat !== 32'h0) begin
      tests_failed++; $display("FAIL read_c0_idle: stb %h dat %h want 00/0", a_stb, a_dat);
    end
    tests_run++;
    if ({a_we, a_adr, a_wdat, a_sel} !== {1'b0, 32'h1000_2010, 32'hCAFE_0001, 4'hF}) begin
      tests_failed++; $display("FAIL broadcast: got %b %h %h %h", a_we, a_adr, a_wdat, a_sel);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      tests_run++;
      if (a_stb !== 8'h04 || a_cyc !== 8'h04 || a_ack !== 1'b0) begin
        tests_failed++; $display("FAIL read_busy c%0d: stb %h cyc %h ack %b want 04/04/0", c, a_stb, a_cyc, a_ack);
      end
    end
    @(negedge clk);
    sack = 8'h04; sdat[2*32 +: 32] = 32'hDEAD_BEEF; we = 1'b1;
    #1;
    tests_run++;
    if (a_ack !== 1'b1 || a_dat !== 32'hDEAD_BEEF || a_err !== 1'b0 || a_we !== 1'b1) begin
      tests_failed++; $display("FAIL read_ack: ack %b dat %h err %b we %b want 1/deadbeef/0/1", a_ack, a_dat, a_err, a_we);
    end
    @(negedge clk);
    stb = 1'b0; sack = '0; we = 1'b0;
    #1;
    tests_run++;
    if (a_stb !== 8'h00 || a_ack !== 1'b0 || a_dat !== 32'h0) begin
      tests_failed++; $display("FAIL read_idle: stb %h ack %b dat %h want 00/0/0", a_stb, a_ack, a_dat);
    end
  endtask

  task automatic test_unmapped();
    @(negedge clk);
    stb = 1'b1; adr = 32'h2000_0000;
    #1;
    tests_run++;
    if (a_stb !== 8'h00 || a_err !== 1'b0) begin
      tests_failed++; $display("FAIL unmapped_c0: stb %h err %b want 00/0", a_stb, a_err);
    end
    @(negedge clk);
    stb = 1'b0;
    #1;
    tests_run++;
    if ({a_err, a_adr_err, a_to_err, a_ack} !== 4'b1100 || a_stb !== 8'h00) begin
      tests_failed++; $display("FAIL unmapped_err: err/adr/to/ack %b stb %h want 1100/00",
        {a_err, a_adr_err, a_to_err, a_ack}, a_stb);
    end
    tests_run++;
    if (a_err_adr !== 32'h2000_0000) begin
      tests_failed++; $display("FAIL unmapped_err_adr: got %h want 20000000", a_err_adr);
    end
    @(negedge clk); #1;
    tests_run++;
    if ({a_err, a_adr_err} !== 2'b00 || a_stb !== 8'h00 || a_err_adr !== 32'h2000_0000) begin
      tests_failed++; $display("FAIL unmapped_after: err %b adr_err %b stb %h err_adr %h",
        a_err, a_adr_err, a_stb, a_err_adr);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    stb = 1'b1; adr = 32'h1000_5004;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      tests_run++;
      if (a_stb !== 8'h20 || a_err !== 1'b0) begin
        tests_failed++; $display("FAIL timeout_busy c%0d: stb %h err %b want 20/0", c, a_stb, a_err);
      end
    end
    @(negedge clk);
    stb = 1'b0;
    #1;
    tests_run++;
    if (a_stb !== 8'h00 || {a_err, a_to_err, a_adr_err, a_ack} !== 4'b1100) begin
      tests_failed++; $display("FAIL timeout_err: stb %h err/to/adr/ack %b want 00/1100",
        a_stb, {a_err, a_to_err, a_adr_err, a_ack});
    end
    tests_run++;
    if (a_err_adr !== 32'h1000_5004) begin
      tests_failed++; $display("FAIL timeout_err_adr: got %h want 10005004", a_err_adr);
    end
    @(negedge clk); #1;
    tests_run++;
    if ({a_err, a_to_err} !== 2'b00) begin
      tests_failed++; $display("FAIL timeout_pulse: err %b to %b want 0/0", a_err, a_to_err);
    end
  endtask

  task automatic test_overlap();
    @(negedge clk);
    stb = 1'b1; adr = 32'h1000_1004;
    sdat[1*32 +: 32] = 32'h1111_1111; sdat[3*32 +: 32] = 32'h3333_3333;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      sack = 8'h08;
      #1;
      tests_run++;
      if (a_stb !== 8'h02 || a_ack !== 1'b0) begin
        tests_failed++; $display("FAIL overlap_spurious c%0d: stb %h ack %b want 02/0", c, a_stb, a_ack);
      end
    end
    @(negedge clk);
    sack = 8'h0A;
    #1;
    tests_run++;
    if (a_ack !== 1'b1 || a_dat !== 32'h1111_1111) begin
      tests_failed++; $display("FAIL overlap_ack: ack %b dat %h want 1/11111111", a_ack, a_dat);
    end
    @(negedge clk);
    stb = 1'b0; sack = '0;
    #1;
  endtask

  task automatic test_abort();
    @(negedge clk);
    stb = 1'b1; adr = 32'h1000_6000;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (a_stb !== 8'h40) begin
      tests_failed++; $display("FAIL abort_busy: stb %h want 40", a_stb);
    end
    @(negedge clk);
    stb = 1'b0;
    #1;
    tests_run++;
    if (a_stb !== 8'h00 || {a_ack, a_err} !== 2'b00) begin
      tests_failed++; $display("FAIL abort_drop: stb %h ack/err %b want 00/00", a_stb, {a_ack, a_err});
    end
    @(negedge clk);
    stb = 1'b1; adr = 32'h1000_0010;
    #1;
    tests_run++;
    if (a_stb !== 8'h00 || {a_ack, a_err} !== 2'b00 || a_dat !== 32'h0) begin
      tests_failed++; $display("FAIL abort_idle: stb %h ack/err %b dat %h want 00/00/0", a_stb, {a_ack, a_err}, a_dat);
    end
    @(negedge clk); #1;
    tests_run++;
    if (a_stb !== 8'h01) begin
      tests_failed++; $display("FAIL abort_redecode: stb %h want 01", a_stb);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (a_stb !== 8'h00 || {a_ack, a_err, a_adr_err, a_to_err} !== 4'b0000 || a_err_adr !== 32'h0) begin
      tests_failed++; $display("FAIL reset_mid_busy: stb %h flags %b err_adr %h want 00/0000/0",
        a_stb, {a_ack, a_err, a_adr_err, a_to_err}, a_err_adr);
    end
    @(negedge clk);
    rst = 1'b1; stb = 1'b0;
  endtask

  task automatic test_ack_at_timeout();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; stb = 1'b1; adr = 32'h1000_2000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      tests_run++;
      if (b_stb !== 8'h04 || b_ack !== 1'b0) begin
        tests_failed++; $display("FAIL ack_to_busy c%0d: stb %h ack %b want 04/0", c, b_stb, b_ack);
      end
    end
    @(negedge clk);
    sack = 8'h04; sdat[2*32 +: 32] = 32'h0123_4567;
    #1;
    tests_run++;
    if (b_ack !== 1'b1 || b_dat !== 32'h0123_4567 || {b_err, b_to_err} !== 2'b00) begin
      tests_failed++; $display("FAIL ack_to_edge: ack %b dat %h err/to %b want 1/01234567/00",
        b_ack, b_dat, {b_err, b_to_err});
    end
    @(negedge clk);
    stb = 1'b0; sack = '0;
    #1;
    tests_run++;
    if ({b_err, b_to_err, b_ack} !== 3'b000 || b_stb !== 8'h00) begin
      tests_failed++; $display("FAIL ack_to_after: err/to/ack %b stb %h want 000/00", {b_err, b_to_err, b_ack}, b_stb);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_unmapped();
    test_timeout();
    test_overlap();
    test_abort();
    test_ack_at_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
